synch_debounce: RTL and testbench
=================================

SYNCH_DEBOUNCE -- requirements
Module: synch_debounce

Interface
REQ-001: Parameter WIDTH, default 4: number of independent channels, range 1..32.
REQ-002: Parameter STAGES, default 2: synchronizer flop depth per channel, range 2..4.
REQ-003: Parameter DEBOUNCE, default 4: consecutive cycles a new synced level must persist before acceptance, range 1..65535.
REQ-004: Parameter INIT, default 0: 1-bit level loaded into every channel's flops at reset.
REQ-005: clk  input  1  sole clock; all flops rising-edge.
REQ-006: rst  input  1  reset, synchronous and active-high.
REQ-007: sig_in  input  WIDTH  asynchronous level inputs, one per channel.
REQ-008: sig_sync  output  WIDTH  registered debounced stable level per channel.
REQ-009: sig_rise  output  WIDTH  one-cycle registered pulse when sig_sync goes 0->1.
REQ-010: sig_fall  output  WIDTH  one-cycle registered pulse when sig_sync goes 1->0.
REQ-011: sig_any  output  1  registered OR of sig_rise|sig_fall across all channels.

Function
REQ-012: Each channel SHALL pass sig_in through a chain of STAGES flops; only the last stage (sync_q) SHALL feed later logic.
REQ-013: Each channel SHALL own a counter of width clog2(DEBOUNCE+1) bits; channels SHALL share no state except sig_any.
REQ-014: If sync_q == sig_sync on an edge, the counter SHALL clear to 0 and sig_sync SHALL hold.
REQ-015: If sync_q != sig_sync and counter < DEBOUNCE-1, the counter SHALL increment by 1.
REQ-016: If sync_q != sig_sync and counter == DEBOUNCE-1, sig_sync SHALL load sync_q and the counter SHALL clear to 0 on the same edge.
REQ-017: A glitch shorter than DEBOUNCE cycles at sync_q SHALL clear the counter when sync_q returns and SHALL NOT change sig_sync.
REQ-018: Counter SHALL never exceed DEBOUNCE-1; no wrap-around is permitted.
REQ-019: sig_rise/sig_fall SHALL assert on the same edge sig_sync updates, for exactly one cycle, and never both on one channel.
REQ-020: sig_any SHALL be registered one cycle after the sig_rise/sig_fall pulse that produced it.
REQ-021: Latency: a sig_in change that is stable ahead of edge 1 SHALL appear on sig_sync, and on the corresponding pulse, at edge STAGES+DEBOUNCE.
REQ-022: DEBOUNCE=1 SHALL accept a change on the first edge where sync_q differs, which is plain STAGES-flop synchronization plus one register.
REQ-023: Simultaneous changes on several channels SHALL be processed independently; sig_any SHALL be a single 1-cycle pulse when all of them coincide.
REQ-024: Toggling sig_in with a period of exactly 2*DEBOUNCE cycles SHALL produce one sig_sync update per half-period after the pipeline fills.

Reset
REQ-025: With rst=1 at an edge, all synchronizer stages and sig_sync SHALL load {WIDTH{INIT}}, counters SHALL load 0, and sig_rise, sig_fall and sig_any SHALL load 0.
REQ-026: Reset SHALL take precedence over every other update, including one mid-debounce; the counters SHALL discard their progress.
REQ-027: Release of reset SHALL produce no rise/fall pulse when sig_in already equals INIT.
REQ-028: When sig_in differs from INIT at reset release, the change SHALL be reported normally after STAGES+DEBOUNCE edges.

Verification
REQ-029: WIDTH=4, STAGES=2, DEBOUNCE=4, INIT=0: drive sig_in[0] 0->1 before edge 1 and hold -> sig_sync[0]=1 and sig_rise[0]=1 at edge 6 only, sig_any=1 at edge 7, other channels 0.
REQ-030: Same configuration: drive sig_in[1] high for 3 cycles -> sig_sync[1] stays 0, no pulses, counter returns to 0.
REQ-031: Same configuration: drive sig_in=4'b1111 at once -> sig_sync=4'b1111 at edge 6, sig_rise=4'b1111 for 1 cycle, one sig_any pulse.
REQ-032: Same configuration: assert rst for 1 cycle while sig_in[2] has been high for 4 cycles (counter=2) -> all outputs 0, and sig_sync[2] rises 6 edges after rst drops.
REQ-033: INIT=1 with sig_in held at all-ones through reset release -> no pulses; then drop sig_in[3] -> sig_fall[3] pulses at edge 6.
REQ-034: DEBOUNCE=1, STAGES=3: a 1-cycle-wide sig_in pulse aligned to an edge -> one sig_rise followed by one sig_fall, 1 cycle apart, starting at edge 4.

Source files
------------

// File: rtl/synch_debounce.sv
// Multi-channel level synchronizer with per-channel debounce and edge pulses.
// Each channel accepts a new synced level only after it persists DEBOUNCE cycles.
module synch_debounce #(
  parameter int   WIDTH    = 4,
  parameter int   STAGES   = 2,
  parameter int   DEBOUNCE = 4,
  parameter logic INIT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] sig_sync,
  output logic [WIDTH-1:0] sig_rise,
  output logic [WIDTH-1:0] sig_fall,
  output logic             sig_any
);

  localparam int             CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] INIT_V = {WIDTH{INIT}};

  // pre_q holds the first STAGES-1 synchronizer flops; sync_q is the last one.
  logic [WIDTH-1:0] pre_q [STAGES-1];
  logic [WIDTH-1:0] pre_d [STAGES-1];
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] sig_sync_q, sig_sync_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             any_q, any_d;

  always_comb begin
    pre_d[0] = sig_in;
    for (int i = 1; i < STAGES - 1; i++) begin
      pre_d[i] = pre_q[i-1];
    end
    sync_d = pre_q[STAGES-2];

    sig_sync_d = sig_sync_q;
    for (int ch = 0; ch < WIDTH; ch++) begin
      cnt_d[ch] = '0;
      // A differing level either advances the count or, on the last count, is accepted.
      if (sync_q[ch] != sig_sync_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) begin
          sig_sync_d[ch] = sync_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CNT_ONE;
        end
      end
    end

    rise_d = sig_sync_d & ~sig_sync_q;
    fall_d = ~sig_sync_d & sig_sync_q;
    any_d  = |(rise_q | fall_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES - 1; i++) begin
        pre_q[i] <= INIT_V;
      end
      sync_q     <= INIT_V;
      sig_sync_q <= INIT_V;
      for (int ch = 0; ch < WIDTH; ch++) begin
        cnt_q[ch] <= '0;
      end
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES - 1; i++) begin
        pre_q[i] <= pre_d[i];
      end
      sync_q     <= sync_d;
      sig_sync_q <= sig_sync_d;
      for (int ch = 0; ch < WIDTH; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign sig_sync = sig_sync_q;
  assign sig_rise = rise_q;
  assign sig_fall = fall_q;
  assign sig_any  = any_q;

endmodule

// File: tb/tb_synch_debounce.sv
// Directed bench for synch_debounce: default config, INIT=1 config, and
// DEBOUNCE=1/STAGES=3 single-channel config, driven from one initial block.
module tb_synch_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=4 STAGES=2 DEBOUNCE=4 INIT=0
  logic       rst0;
  logic [3:0] in0, sync0, rise0, fall0;
  logic       any0;
  // Instance 1: WIDTH=4 STAGES=2 DEBOUNCE=4 INIT=1
  logic       rst1;
  logic [3:0] in1, sync1, rise1, fall1;
  logic       any1;
  // Instance 2: WIDTH=1 STAGES=3 DEBOUNCE=1 INIT=0
  logic       rst2;
  logic [0:0] in2, sync2, rise2, fall2;
  logic       any2;

  synch_debounce #(.WIDTH(4), .STAGES(2), .DEBOUNCE(4), .INIT(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .sig_in(in0), .sig_sync(sync0),
    .sig_rise(rise0), .sig_fall(fall0), .sig_any(any0)
  );
  synch_debounce #(.WIDTH(4), .STAGES(2), .DEBOUNCE(4), .INIT(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .sig_in(in1), .sig_sync(sync1),
    .sig_rise(rise1), .sig_fall(fall1), .sig_any(any1)
  );
  synch_debounce #(.WIDTH(1), .STAGES(3), .DEBOUNCE(1), .INIT(1'b0)) dut2 (
    .clk(clk), .rst(rst2), .sig_in(in2), .sig_sync(sync2),
    .sig_rise(rise2), .sig_fall(fall2), .sig_any(any2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk0(input string tag, input logic [3:0] s, input logic [3:0] r,
                      input logic [3:0] f, input logic a);
    chk({tag, "_sync"}, sync0, s);
    chk({tag, "_rise"}, rise0, r);
    chk({tag, "_fall"}, fall0, f);
    chk({tag, "_any"},  4'(any0), 4'(a));
  endtask

  // Apply vin to instance 0 ahead of edge 1 and check n edges; upd_edge=0 means
  // no update is expected, otherwise sig_sync moves old_s->new_s at that edge.
  task automatic pulse_run(input string tag, input logic [3:0] vin, input int n,
                           input int upd_edge, input logic [3:0] old_s,
                           input logic [3:0] new_s);
    logic [3:0] es, er, ef;
    logic       ea;
    in0 = vin;
    for (int e = 1; e <= n; e++) begin
      step();
      es = (upd_edge > 0 && e >= upd_edge) ? new_s : old_s;
      er = (upd_edge > 0 && e == upd_edge) ? (new_s & ~old_s) : 4'b0000;
      ef = (upd_edge > 0 && e == upd_edge) ? (old_s & ~new_s) : 4'b0000;
      ea = (upd_edge > 0 && e == upd_edge + 1);
      chk0($sformatf("%s_e%0d", tag, e), es, er, ef, ea);
    end
  endtask

  initial begin
    logic [3:0] es, er, ef;
    logic       ea;

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    in0 = 4'b0000; in1 = 4'b1111; in2 = 1'b0;
    step();
    step();
    chk0("reset0", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("reset1_sync", sync1, 4'b1111);
    chk("reset1_rise", rise1, 4'b0000);
    chk("reset1_fall", fall1, 4'b0000);
    chk("reset1_any",  4'(any1), 4'b0000);
    chk("reset2_sync", 4'(sync2), 4'b0000);
    chk("reset2_any",  4'(any2), 4'b0000);

    // Release with inputs equal to INIT: no pulses anywhere.
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk0($sformatf("rel0_e%0d", e), 4'b0000, 4'b0000, 4'b0000, 1'b0);
      chk($sformatf("rel1_sync_e%0d", e), sync1, 4'b1111);
      chk($sformatf("rel1_rise_e%0d", e), rise1, 4'b0000);
      chk($sformatf("rel1_fall_e%0d", e), fall1, 4'b0000);
      chk($sformatf("rel1_any_e%0d", e),  4'(any1), 4'b0000);
    end

    // INIT=1 instance: drop channel 3, fall pulse at edge 6.
    in1 = 4'b0111;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("init1_sync_e%0d", e), sync1, (e >= 6) ? 4'b0111 : 4'b1111);
      chk($sformatf("init1_fall_e%0d", e), fall1, (e == 6) ? 4'b1000 : 4'b0000);
      chk($sformatf("init1_rise_e%0d", e), rise1, 4'b0000);
      chk($sformatf("init1_any_e%0d", e),  4'(any1), (e == 7) ? 4'b0001 : 4'b0000);
    end

    // DEBOUNCE=1 STAGES=3: one-cycle pulse -> rise at edge 4, fall at edge 5.
    in2 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 1) in2 = 1'b0;
      chk($sformatf("db1_sync_e%0d", e), 4'(sync2), (e == 4) ? 4'b0001 : 4'b0000);
      chk($sformatf("db1_rise_e%0d", e), 4'(rise2), (e == 4) ? 4'b0001 : 4'b0000);
      chk($sformatf("db1_fall_e%0d", e), 4'(fall2), (e == 5) ? 4'b0001 : 4'b0000);
      chk($sformatf("db1_any_e%0d", e),  4'(any2), (e == 5 || e == 6) ? 4'b0001 : 4'b0000);
    end

    // Single-channel rise and fall with DEBOUNCE=4.
    pulse_run("rise0", 4'b0001, 8, 6, 4'b0000, 4'b0001);
    pulse_run("fall0", 4'b0000, 8, 6, 4'b0001, 4'b0000);

    // 3-cycle glitch is rejected; a following held level still needs the full count.
    pulse_run("glitch1_hi", 4'b0010, 3, 0, 4'b0000, 4'b0000);
    pulse_run("glitch1_lo", 4'b0000, 8, 0, 4'b0000, 4'b0000);
    pulse_run("hold1",      4'b0010, 8, 6, 4'b0000, 4'b0010);
    pulse_run("rel1",       4'b0000, 8, 6, 4'b0010, 4'b0000);

    // All channels together: one sig_any pulse.
    pulse_run("all_rise", 4'b1111, 8, 6, 4'b0000, 4'b1111);
    pulse_run("all_fall", 4'b0000, 8, 6, 4'b1111, 4'b0000);

    // Reset mid-debounce discards progress.
    pulse_run("pre_rst", 4'b0100, 4, 0, 4'b0000, 4'b0000);
    rst0 = 1'b1;
    step();
    chk0("mid_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst0 = 1'b0;
    pulse_run("post_rst",  4'b0100, 8, 6, 4'b0000, 4'b0100);
    pulse_run("post_fall", 4'b0000, 8, 6, 4'b0100, 4'b0000);

    // Toggle channel 0 with period 2*DEBOUNCE: one update every 4 edges.
    for (int e = 1; e <= 24; e++) begin
      if (e == 1 || e == 5 || e == 9 || e == 13 || e == 17) in0[0] = ~in0[0];
      step();
      es = ((e >= 6 && e < 10) || (e >= 14 && e < 18) || e >= 22) ? 4'b0001 : 4'b0000;
      er = (e == 6 || e == 14 || e == 22) ? 4'b0001 : 4'b0000;
      ef = (e == 10 || e == 18) ? 4'b0001 : 4'b0000;
      ea = (e == 7 || e == 11 || e == 15 || e == 19 || e == 23);
      chk0($sformatf("tog_e%0d", e), es, er, ef, ea);
    end
    pulse_run("tog_end", 4'b0000, 8, 6, 4'b0001, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
